line_draw_engine: RTL

//  Parametrised Bresenham line rasteriser: latches two endpoints and a colour on a

---
 rtl/line_draw_engine.sv | 122 ++++++++++++
 1 files changed

// File: rtl/line_draw_engine.sv
// Bresenham line rasteriser: latches two endpoints and a colour on start, then
// streams one pixel per plot_valid/plot_ready handshake, any octant.
module line_draw_engine #(
  parameter int XW = 9,
  parameter int YW = 8,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y0,
  input  logic [YW-1:0] y1,
  input  logic [CW-1:0] colour_in,
  input  logic          plot_ready,
  output logic          plot_valid,
  output logic [XW-1:0] plot_x,
  output logic [YW-1:0] plot_y,
  output logic [CW-1:0] plot_colour,
  output logic          busy,
  output logic          done
);
  localparam int MW = (XW > YW) ? XW : YW;
  localparam int EW = MW + 2;

  typedef enum logic [1:0] {IDLE, SETUP, PLOT, DONE} state_t;
  state_t r_state, w_next;

  logic [MW-1:0] r_x0, r_x1, r_y0, r_y1;
  logic [CW-1:0] r_colour;
  logic          r_steep, r_yneg;
  logic [MW-1:0] r_major, r_major_end, r_minor, r_dx, r_dy;
  logic signed [EW-1:0] r_err;

  logic [MW-1:0] w_adx, w_ady, w_a0, w_a1, w_b0, w_b1;
  logic [MW-1:0] w_maj0, w_maj1, w_min0, w_min1, w_dx, w_dy;
  logic          w_steep, w_swap, w_yneg, w_last;
  logic signed [EW-1:0] w_dx_s, w_dy_s, w_e;

  // Setup: fold into a shallow, left-to-right octant on the major axis.
  assign w_adx   = (r_x1 >= r_x0) ? r_x1 - r_x0 : r_x0 - r_x1;
  assign w_ady   = (r_y1 >= r_y0) ? r_y1 - r_y0 : r_y0 - r_y1;
  assign w_steep = w_ady > w_adx;
  assign w_a0    = w_steep ? r_y0 : r_x0;
  assign w_a1    = w_steep ? r_y1 : r_x1;
  assign w_b0    = w_steep ? r_x0 : r_y0;
  assign w_b1    = w_steep ? r_x1 : r_y1;
  assign w_swap  = w_a0 > w_a1;
  assign w_maj0  = w_swap ? w_a1 : w_a0;
  assign w_maj1  = w_swap ? w_a0 : w_a1;
  assign w_min0  = w_swap ? w_b1 : w_b0;
  assign w_min1  = w_swap ? w_b0 : w_b1;
  assign w_dx    = w_maj1 - w_maj0;
  assign w_dy    = (w_min1 >= w_min0) ? w_min1 - w_min0 : w_min0 - w_min1;
  assign w_yneg  = w_min0 > w_min1;

  assign w_dx_s = EW'(r_dx);
  assign w_dy_s = EW'(r_dy);
  assign w_e    = r_err - w_dy_s;
  assign w_last = (r_major == r_major_end);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SETUP;
      SETUP:   w_next = PLOT;
      PLOT:    if (plot_ready && w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    plot_valid = (r_state == PLOT);
    busy       = (r_state != IDLE);
    done       = (r_state == DONE);
  end

  assign plot_x      = r_steep ? r_minor[XW-1:0] : r_major[XW-1:0];
  assign plot_y      = r_steep ? r_major[YW-1:0] : r_minor[YW-1:0];
  assign plot_colour = r_colour;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x0 <= '0; r_x1 <= '0; r_y0 <= '0; r_y1 <= '0;
      r_colour <= '0; r_steep <= 1'b0; r_yneg <= 1'b0;
      r_major <= '0; r_major_end <= '0; r_minor <= '0;
      r_dx <= '0; r_dy <= '0; r_err <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_x0 <= MW'(x0); r_x1 <= MW'(x1);
        r_y0 <= MW'(y0); r_y1 <= MW'(y1);
        r_colour <= colour_in;
      end
      if (r_state == SETUP) begin
        r_steep     <= w_steep;
        r_yneg      <= w_yneg;
        r_major     <= w_maj0;
        r_major_end <= w_maj1;
        r_minor     <= w_min0;
        r_dx        <= w_dx;
        r_dy        <= w_dy;
        r_err       <= EW'(w_dx >> 1);
      end
      if (r_state == PLOT && plot_ready && !w_last) begin
        r_major <= r_major + MW'(1);
        if (w_e[EW-1]) begin
          r_minor <= r_yneg ? r_minor - MW'(1) : r_minor + MW'(1);
          r_err   <= w_e + w_dx_s;
        end else begin
          r_err <= w_e;
        end
      end
    end
  end
endmodule
